rggen_axi4lite_bridge: RTL



---
 rtl/rggen_rtl_pkg.sv | 20 ++
 rtl/rggen_axi4lite_if.sv | 45 ++++
 rtl/rggen_axi4lite_rw_arbiter.sv | 43 ++++
 rtl/rggen_axi4lite_bridge.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen AXI4-Lite bridge.
//   rggen_status               : 2-bit register-bus response status
//   rggen_axi4lite_bridge_state : bridge FSM states
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUS_ACCESS     = 2'd1,
    WRITE_RESPONSE = 2'd2,
    READ_RESPONSE  = 2'd3
  } rggen_axi4lite_bridge_state;

endpackage

// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite channel bundle.
//   master : drives AW/W/AR valid+payload and B/R ready
//   slave  : drives AW/W/AR ready and B/R valid+payload
interface rggen_axi4lite_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 32
);

  logic                       awvalid;
  logic                       awready;
  logic [ADDRESS_WIDTH-1:0]   awaddr;
  logic [2:0]                 awprot;
  logic                       wvalid;
  logic                       wready;
  logic [BUS_WIDTH-1:0]       wdata;
  logic [BUS_WIDTH/8-1:0]     wstrb;
  logic                       bvalid;
  logic                       bready;
  logic [1:0]                 bresp;
  logic                       arvalid;
  logic                       arready;
  logic [ADDRESS_WIDTH-1:0]   araddr;
  logic [2:0]                 arprot;
  logic                       rvalid;
  logic                       rready;
  logic [1:0]                 rresp;
  logic [BUS_WIDTH-1:0]       rdata;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input  rvalid, rresp, rdata, output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rresp, rdata, input rready
  );

endinterface

// File: rtl/rggen_axi4lite_rw_arbiter.sv
// Read/write grant arbiter with a toggling priority flag.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_write_request     : AW and W both valid
//   i_read_request      : AR valid
//   i_grant_enable      : bridge can accept a new access this cycle
//   o_write_grant/o_read_grant : one-hot or zero grant (combinational)
module rggen_axi4lite_rw_arbiter (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_write_request,
  input  logic i_read_request,
  input  logic i_grant_enable,
  output logic o_write_grant,
  output logic o_read_grant
);

  logic r_write_first;
  logic w_contended;

  assign w_contended = i_grant_enable & i_write_request & i_read_request;

  // Priority flag only matters, and only flips, when both sides compete.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_write_first <= 1'b1;
    end else if (w_contended) begin
      r_write_first <= ~r_write_first;
    end
  end

  always_comb begin
    o_write_grant = 1'b0;
    o_read_grant  = 1'b0;
    if (w_contended) begin
      o_write_grant = r_write_first;
      o_read_grant  = ~r_write_first;
    end else if (i_grant_enable) begin
      o_write_grant = i_write_request;
      o_read_grant  = i_read_request;
    end
  end

endmodule

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen register-bus bridge, one outstanding access.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   axi4lite_if       : AXI4-Lite slave side
//   o_bus_*           : register access request (valid/write/address/data/strobe)
//   i_bus_ready       : access complete; i_bus_status / i_bus_read_data captured
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 32
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  rggen_axi4lite_if.slave          axi4lite_if,
  output logic                     o_bus_valid,
  output logic                     o_bus_write,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned ADDR_LSB     = $clog2(STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
    ~ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);

  rggen_axi4lite_bridge_state r_state;
  rggen_axi4lite_bridge_state w_next_state;

  logic                     r_bus_write;
  logic [ADDRESS_WIDTH-1:0] r_bus_address;
  logic [BUS_WIDTH-1:0]     r_bus_write_data;
  logic [STROBE_WIDTH-1:0]  r_bus_strobe;
  rggen_status              r_status;
  logic [BUS_WIDTH-1:0]     r_read_data;

  logic w_write_request;
  logic w_read_request;
  logic w_grant_enable;
  logic w_write_grant;
  logic w_read_grant;
  logic w_unused_prot;

  assign w_unused_prot = ^{axi4lite_if.awprot, axi4lite_if.arprot};

  // A write needs AW and W together; grants are withheld during reset.
  assign w_write_request = axi4lite_if.awvalid & axi4lite_if.wvalid;
  assign w_read_request  = axi4lite_if.arvalid;
  assign w_grant_enable  = (r_state == IDLE) & ~i_rst;

  rggen_axi4lite_rw_arbiter u_arbiter (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_write_request (w_write_request),
    .i_read_request  (w_read_request),
    .i_grant_enable  (w_grant_enable),
    .o_write_grant   (w_write_grant),
    .o_read_grant    (w_read_grant)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_write_grant || w_read_grant) begin
          w_next_state = BUS_ACCESS;
        end
      end
      BUS_ACCESS: begin
        if (i_bus_ready) begin
          w_next_state = r_bus_write ? WRITE_RESPONSE : READ_RESPONSE;
        end
      end
      WRITE_RESPONSE: begin
        if (axi4lite_if.bready) begin
          w_next_state = IDLE;
        end
      end
      READ_RESPONSE: begin
        if (axi4lite_if.rready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture at grant; status/read data capture at bus completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_write      <= 1'b0;
      r_bus_address    <= '0;
      r_bus_write_data <= '0;
      r_bus_strobe     <= '0;
      r_status         <= RGGEN_OKAY;
      r_read_data      <= '0;
    end else begin
      if (w_write_grant) begin
        r_bus_write      <= 1'b1;
        r_bus_address    <= axi4lite_if.awaddr & ADDR_MASK;
        r_bus_write_data <= axi4lite_if.wdata;
        r_bus_strobe     <= axi4lite_if.wstrb;
      end else if (w_read_grant) begin
        r_bus_write      <= 1'b0;
        r_bus_address    <= axi4lite_if.araddr & ADDR_MASK;
        r_bus_write_data <= '0;
        r_bus_strobe     <= '1;
      end
      if ((r_state == BUS_ACCESS) && i_bus_ready) begin
        r_status <= rggen_status'(i_bus_status);
        if (!r_bus_write) begin
          r_read_data <= i_bus_read_data;
        end
      end
    end
  end

  // Valids decode the registered state only; readys are the IDLE grants.
  assign o_bus_valid      = (r_state == BUS_ACCESS);
  assign o_bus_write      = r_bus_write;
  assign o_bus_address    = r_bus_address;
  assign o_bus_write_data = r_bus_write_data;
  assign o_bus_strobe     = r_bus_strobe;

  assign axi4lite_if.awready = w_write_grant;
  assign axi4lite_if.wready  = w_write_grant;
  assign axi4lite_if.arready = w_read_grant;
  assign axi4lite_if.bvalid  = (r_state == WRITE_RESPONSE);
  assign axi4lite_if.bresp   = r_status;
  assign axi4lite_if.rvalid  = (r_state == READ_RESPONSE);
  assign axi4lite_if.rresp   = r_status;
  assign axi4lite_if.rdata   = r_read_data;

endmodule
